// File: rtl/jtag_dtm.sv
// RISC-V debug transport module: owns the DTMCS and DMI scan registers
// behind the JTAG TAP and turns completed DMI scans into valid/ready
// request/response transactions toward the debug module.
module jtag_dtm #(
   parameter int unsigned          IR_WIDTH  = 5,
   parameter int unsigned          ABITS     = 7,
   parameter logic [IR_WIDTH-1:0]  DTMCS_IR  = 'h10,
   parameter logic [IR_WIDTH-1:0]  DMI_IR    = 'h11,
   parameter logic [2:0]           IDLE_HINT = 3'd1
) (
   input  logic                TCLK,
   input  logic                TRST,
   input  logic [IR_WIDTH-1:0] ir,
   input  logic                dr_capture,
   input  logic                dr_shift,
   input  logic                dr_update,
   input  logic                TDI,
   output logic                dr_tdo,
   output logic                dmi_req_valid,
   input  logic                dmi_req_ready,
   output logic [ABITS-1:0]    dmi_req_addr,
   output logic [31:0]         dmi_req_data,
   output logic [1:0]          dmi_req_op,
   input  logic                dmi_rsp_valid,
   output logic                dmi_rsp_ready,
   input  logic [31:0]         dmi_rsp_data,
   input  logic [1:0]          dmi_rsp_op
);

   localparam int unsigned W       = ABITS + 34;
   localparam logic [5:0]  ABITS_F = 6'(ABITS);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_e;

   state_e             state_q, state_d;
   logic [1:0]         sticky_q, sticky_d;
   logic [ABITS-1:0]   last_addr_q, last_addr_d;
   logic [31:0]        last_data_q, last_data_d;
   logic [1:0]         op_q, op_d;
   logic [W-1:0]       sr_q, sr_d;

   logic sel_dtmcs, sel_dmi, busy;

   assign sel_dtmcs = (ir == DTMCS_IR);
   assign sel_dmi   = (ir == DMI_IR);
   assign busy      = (state_q != ST_IDLE);

   // Serial output and DMI port outputs derived from the registered state
   always_comb begin
      dr_tdo        = (sel_dtmcs || sel_dmi) ? sr_q[0] : 1'b0;
      dmi_req_valid = (state_q == ST_REQ);
      dmi_rsp_ready = (state_q == ST_RSP);
      dmi_req_addr  = last_addr_q;
      dmi_req_data  = last_data_q;
      dmi_req_op    = op_q;
   end

   // Next-state: DMI handshake first, then TAP capture/shift/update on top
   always_comb begin
      state_d     = state_q;
      sticky_d    = sticky_q;
      last_addr_d = last_addr_q;
      last_data_d = last_data_q;
      op_d        = op_q;
      sr_d        = sr_q;

      case (state_q)
         ST_REQ: if (dmi_req_ready) state_d = ST_RSP;
         ST_RSP: begin
            if (dmi_rsp_valid) begin
               state_d = ST_IDLE;
               if (op_q == 2'd1) last_data_d = dmi_rsp_data;
               if (sticky_q == 2'd0) begin
                  if (dmi_rsp_op == 2'd2)      sticky_d = 2'd2;
                  else if (dmi_rsp_op == 2'd3) sticky_d = 2'd3;
               end
            end
         end
         default: ;
      endcase

      if (dr_capture) begin
         if (sel_dtmcs) begin
            sr_d[31:0] = {14'b0, 1'b0, 1'b0, 1'b0, IDLE_HINT, sticky_q, ABITS_F, 4'h1};
         end else if (sel_dmi) begin
            sr_d = {last_addr_q, last_data_q, busy ? 2'd3 : sticky_q};
            if (busy && sticky_d == 2'd0) sticky_d = 2'd3;
         end
      end else if (dr_shift) begin
         if (sel_dtmcs)    sr_d[31:0] = {TDI, sr_q[31:1]};
         else if (sel_dmi) sr_d       = {TDI, sr_q[W-1:1]};
      end else if (dr_update) begin
         if (sel_dtmcs) begin
            // Hard reset also discards any response landing this cycle
            if (sr_q[17]) begin
               sticky_d    = 2'd0;
               state_d     = ST_IDLE;
               last_data_d = last_data_q;
            end else if (sr_q[16]) begin
               sticky_d = 2'd0;
            end
         end else if (sel_dmi) begin
            if (sticky_q != 2'd0) begin
               // error latched: drop the scan
            end else if (busy) begin
               if (sticky_d == 2'd0) sticky_d = 2'd3;
            end else if (sr_q[1:0] == 2'd1 || sr_q[1:0] == 2'd2) begin
               last_addr_d = sr_q[W-1:34];
               if (sr_q[1:0] == 2'd2) last_data_d = sr_q[33:2];
               op_d    = sr_q[1:0];
               state_d = ST_REQ;
            end
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge TCLK or posedge TRST) begin
      if (TRST) begin
         state_q     <= ST_IDLE;
         sticky_q    <= '0;
         last_addr_q <= '0;
         last_data_q <= '0;
         op_q        <= '0;
         sr_q        <= '0;
      end else begin
         state_q     <= state_d;
         sticky_q    <= sticky_d;
         last_addr_q <= last_addr_d;
         last_data_q <= last_data_d;
         op_q        <= op_d;
         sr_q        <= sr_d;
      end
   end

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: drives TAP scans and a hand-operated DM port.
module tb_jtag_dtm;

   logic        TCLK = 1'b0;
   logic        TRST = 1'b1;
   logic [4:0]  ir = '0;
   logic        dr_capture = 1'b0;
   logic        dr_shift = 1'b0;
   logic        dr_update = 1'b0;
   logic        TDI = 1'b0;
   logic        dr_tdo;
   logic        dmi_req_valid;
   logic        dmi_req_ready = 1'b0;
   logic [6:0]  dmi_req_addr;
   logic [31:0] dmi_req_data;
   logic [1:0]  dmi_req_op;
   logic        dmi_rsp_valid = 1'b0;
   logic        dmi_rsp_ready;
   logic [31:0] dmi_rsp_data = '0;
   logic [1:0]  dmi_rsp_op = '0;

   int unsigned checks = 0;
   int unsigned failures = 0;
   logic [40:0] dout;

   localparam logic [4:0] IR_DTMCS = 5'h10;
   localparam logic [4:0] IR_DMI   = 5'h11;

   jtag_dtm #(.IR_WIDTH(5), .ABITS(7), .DTMCS_IR(5'h10), .DMI_IR(5'h11), .IDLE_HINT(3'd1)) dut (
      .TCLK(TCLK), .TRST(TRST), .ir(ir),
      .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
      .TDI(TDI), .dr_tdo(dr_tdo),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
      .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
      .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op)
   );

   always #5 TCLK = ~TCLK;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [40:0] word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
      return {a, d, op};
   endfunction

   // Capture, shift n bits LSB first (collecting TDO), then update; returns at a negedge
   task automatic scan(input logic [4:0] irv, input int unsigned n, input logic [40:0] din,
                       output logic [40:0] dq);
      dq = '0;
      @(negedge TCLK);
      ir = irv;
      dr_capture = 1'b1;
      @(negedge TCLK);
      dr_capture = 1'b0;
      dr_shift = 1'b1;
      for (int unsigned i = 0; i < n; i++) begin
         TDI = din[i];
         #1 dq[i] = dr_tdo;
         @(negedge TCLK);
      end
      dr_shift = 1'b0;
      dr_update = 1'b1;
      @(negedge TCLK);
      dr_update = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge TCLK);
      check("rst_valid", dmi_req_valid, 1'b0);
      check("rst_rsp_ready", dmi_rsp_ready, 1'b0);
      check("rst_addr", dmi_req_addr, 7'h0);
      check("rst_data", dmi_req_data, 32'h0);
      check("rst_op", dmi_req_op, 2'd0);
      check("rst_tdo", dr_tdo, 1'b0);
      TRST = 1'b0;
      @(negedge TCLK);

      // DTMCS readout
      scan(IR_DTMCS, 32, '0, dout);
      check("dtmcs_reset", dout[31:0], 32'h00001071);

      // Non-selected IR has no effect
      scan(5'h01, 41, word(7'h04, 32'hDEADBEEF, 2'd2), dout);
      check("nosel_tdo", dout, 41'h0);
      check("nosel_valid", dmi_req_valid, 1'b0);

      // Write with ready held low for three cycles
      scan(IR_DMI, 41, word(7'h04, 32'hDEADBEEF, 2'd2), dout);
      check("wr_capture", dout, word(7'h00, 32'h0, 2'd0));
      for (int unsigned i = 0; i < 3; i++) begin
         check("wr_valid", dmi_req_valid, 1'b1);
         check("wr_addr", dmi_req_addr, 7'h04);
         check("wr_data", dmi_req_data, 32'hDEADBEEF);
         check("wr_op", dmi_req_op, 2'd2);
         @(negedge TCLK);
      end
      dmi_req_ready = 1'b1;
      @(negedge TCLK);
      dmi_req_ready = 1'b0;
      check("wr_acc_valid", dmi_req_valid, 1'b0);
      check("wr_rsp_ready", dmi_rsp_ready, 1'b1);
      dmi_rsp_valid = 1'b1;
      @(negedge TCLK);
      dmi_rsp_valid = 1'b0;
      check("wr_done", dmi_rsp_ready, 1'b0);

      // Zero-wait read, result returned in next capture
      scan(IR_DMI, 41, word(7'h11, 32'h0, 2'd1), dout);
      check("rd_valid", dmi_req_valid, 1'b1);
      check("rd_op", dmi_req_op, 2'd1);
      check("rd_addr", dmi_req_addr, 7'h11);
      dmi_req_ready = 1'b1;
      dmi_rsp_valid = 1'b1;
      dmi_rsp_data  = 32'h12345678;
      dmi_rsp_op    = 2'd0;
      @(negedge TCLK);
      dmi_req_ready = 1'b0;
      check("rd_in_rsp", dmi_rsp_ready, 1'b1);
      @(negedge TCLK);
      dmi_rsp_valid = 1'b0;
      check("rd_idle", dmi_rsp_ready, 1'b0);
      scan(IR_DMI, 41, '0, dout);
      check("rd_result", dout, word(7'h11, 32'h12345678, 2'd0));

      // Busy: capture while response outstanding
      scan(IR_DMI, 41, word(7'h05, 32'h0, 2'd1), dout);
      dmi_req_ready = 1'b1;
      @(negedge TCLK);
      dmi_req_ready = 1'b0;
      check("busy_rsp_ready", dmi_rsp_ready, 1'b1);
      scan(IR_DMI, 41, word(7'h06, 32'h0, 2'd1), dout);
      check("busy_capture", dout, word(7'h05, 32'h12345678, 2'd3));
      check("busy_no_req", dmi_req_valid, 1'b0);
      dmi_rsp_valid = 1'b1;
      dmi_rsp_data  = 32'hAAAA5555;
      @(negedge TCLK);
      dmi_rsp_valid = 1'b0;
      check("busy_rsp_done", dmi_rsp_ready, 1'b0);
      scan(IR_DMI, 41, word(7'h07, 32'h0, 2'd1), dout);
      check("busy_sticky", dout, word(7'h05, 32'hAAAA5555, 2'd3));
      check("busy_blocked", dmi_req_valid, 1'b0);
      scan(IR_DTMCS, 32, 41'h10000, dout);
      check("busy_dmistat", dout[31:0], 32'h00001C71);
      scan(IR_DTMCS, 32, '0, dout);
      check("dmireset_clear", dout[31:0], 32'h00001071);

      // Failed response
      scan(IR_DMI, 41, word(7'h08, 32'h0, 2'd1), dout);
      dmi_req_ready = 1'b1;
      dmi_rsp_valid = 1'b1;
      dmi_rsp_op    = 2'd2;
      dmi_rsp_data  = 32'hCAFEF00D;
      @(negedge TCLK);
      dmi_req_ready = 1'b0;
      @(negedge TCLK);
      dmi_rsp_valid = 1'b0;
      dmi_rsp_op    = 2'd0;
      scan(IR_DTMCS, 32, '0, dout);
      check("fail_dmistat", dout[31:0], 32'h00001871);
      scan(IR_DMI, 41, word(7'h09, 32'h11111111, 2'd2), dout);
      check("fail_capture", dout, word(7'h08, 32'hCAFEF00D, 2'd2));
      check("fail_blocked", dmi_req_valid, 1'b0);
      scan(IR_DTMCS, 32, 41'h10000, dout);
      check("fail_dmistat2", dout[31:0], 32'h00001871);
      scan(IR_DMI, 41, word(7'h0A, 32'h01020304, 2'd2), dout);
      check("after_reset_cap", dout, word(7'h08, 32'hCAFEF00D, 2'd0));
      check("after_reset_valid", dmi_req_valid, 1'b1);
      check("after_reset_addr", dmi_req_addr, 7'h0A);
      check("after_reset_data", dmi_req_data, 32'h01020304);
      dmi_req_ready = 1'b1;
      @(negedge TCLK);
      dmi_req_ready = 1'b0;
      dmi_rsp_valid = 1'b1;
      dmi_rsp_data  = 32'hFFFFFFFF;
      @(negedge TCLK);
      dmi_rsp_valid = 1'b0;

      // TRST during REQ
      scan(IR_DMI, 41, word(7'h0B, 32'h00000055, 2'd2), dout);
      check("wr2_capture", dout, word(7'h0A, 32'h01020304, 2'd0));
      check("wr2_valid", dmi_req_valid, 1'b1);
      TRST = 1'b1;
      #1;
      check("trst_valid", dmi_req_valid, 1'b0);
      check("trst_addr", dmi_req_addr, 7'h0);
      @(negedge TCLK);
      TRST = 1'b0;
      scan(IR_DTMCS, 32, '0, dout);
      check("trst_dtmcs", dout[31:0], 32'h00001071);
      scan(IR_DMI, 41, '0, dout);
      check("trst_dmi", dout, 41'h0);

      // Hard reset while in RSP, late response ignored
      scan(IR_DMI, 41, word(7'h0C, 32'h0, 2'd1), dout);
      dmi_req_ready = 1'b1;
      @(negedge TCLK);
      dmi_req_ready = 1'b0;
      check("hr_in_rsp", dmi_rsp_ready, 1'b1);
      scan(IR_DTMCS, 32, 41'h20000, dout);
      check("hr_dtmcs", dout[31:0], 32'h00001071);
      check("hr_rsp_ready", dmi_rsp_ready, 1'b0);
      check("hr_valid", dmi_req_valid, 1'b0);
      dmi_rsp_valid = 1'b1;
      dmi_rsp_data  = 32'hBADBAD00;
      dmi_rsp_op    = 2'd2;
      @(negedge TCLK);
      dmi_rsp_valid = 1'b0;
      dmi_rsp_op    = 2'd0;
      scan(IR_DTMCS, 32, '0, dout);
      check("hr_late_stat", dout[31:0], 32'h00001071);
      scan(IR_DMI, 41, '0, dout);
      check("hr_late_data", dout, word(7'h0C, 32'h0, 2'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
